// File: rtl/vram_txt_pkg.sv
// Shared types and constants for the text-console VRAM writer.
package vram_txt_pkg;

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_LINE} state_t;

  typedef logic [11:0] color_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vram_clr_seq.sv
// Base/length address sequencer: one write strobe per cycle while active, done on the last.
module vram_clr_seq #(
  parameter int P_ADR_BIT = 13,
  parameter int P_LEN_W   = 14,
  parameter int P_RST_LEN = 4800
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [P_ADR_BIT-1:0] base,
  input  logic [P_LEN_W-1:0]   len,
  output logic [P_ADR_BIT-1:0] adr,
  output logic                 wr,
  output logic                 done
);

  logic [P_ADR_BIT-1:0] cur;
  logic [P_LEN_W-1:0]   rem;
  logic                 act;

  // Reset comes up already running a sweep from address 0 so the screen blanks itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 1'b1;
      cur <= '0;
      rem <= P_LEN_W'(P_RST_LEN);
    end else if (start) begin
      act <= (len != '0);
      cur <= base;
      rem <= len;
    end else if (act) begin
      cur <= cur + P_ADR_BIT'(1);
      rem <= rem - P_LEN_W'(1);
      if (rem == P_LEN_W'(1)) act <= 1'b0;
    end
  end

  assign adr  = cur;
  assign wr   = act;
  assign done = act && (rem == P_LEN_W'(1));

endmodule

// File: rtl/vram_txt_wr.sv
// Text-console writer: turns a character byte stream into VRAM writes with cursor tracking.
module vram_txt_wr
  import vram_txt_pkg::*;
#(
  parameter int         P_COLS    = 80,
  parameter int         P_ROWS    = 60,
  parameter int         P_ADR_BIT = 13,
  parameter logic [7:0] P_CLR_CHR = 8'h20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_chr_vld,
  input  logic [7:0]           i_chr_dt,
  input  color_t               i_col,
  output logic                 o_chr_rdy,
  input  logic                 i_clr,
  output logic [P_ADR_BIT-1:0] o_vram_wr_adr,
  output logic                 o_vram_wr_en,
  output logic [7:0]           o_vram_wr_chr,
  output color_t               o_vram_wr_col,
  output logic [6:0]           o_cur_col,
  output logic [5:0]           o_cur_row,
  output logic                 o_busy
);

  localparam int TOTAL = P_COLS * P_ROWS;
  localparam int LEN_W = P_ADR_BIT + 1;

  state_t               state, next_state;
  logic [P_ADR_BIT-1:0] line_base, nxt_base;
  logic                 accept, is_prt, is_bs, is_cr, row_adv, full_clr;
  logic                 last_col, last_row;
  logic                 seq_start, seq_wr, seq_done;
  logic [P_ADR_BIT-1:0] seq_base, seq_adr;
  logic [LEN_W-1:0]     seq_len;

  assign o_chr_rdy = (state == IDLE) && !i_clr;
  assign accept    = i_chr_vld && o_chr_rdy;
  assign last_col  = (o_cur_col == 7'(P_COLS - 1));
  assign last_row  = (o_cur_row == 6'(P_ROWS - 1));
  assign is_prt    = accept && is_print(i_chr_dt);
  assign is_bs     = accept && (i_chr_dt == BS) && (o_cur_col != 7'd0);
  assign is_cr     = accept && (i_chr_dt == CR);
  assign row_adv   = accept && ((i_chr_dt == LF) || (is_print(i_chr_dt) && last_col));
  assign full_clr  = i_clr || (accept && (i_chr_dt == FF));
  assign nxt_base  = last_row ? '0 : line_base + P_ADR_BIT'(P_COLS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= CLR_ALL;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (full_clr) begin
      next_state = CLR_ALL;
    end else begin
      case (state)
        IDLE:              if (row_adv)  next_state = CLR_LINE;
        CLR_ALL, CLR_LINE: if (seq_done) next_state = IDLE;
        default:                         next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    seq_start = full_clr || row_adv;
    seq_base  = full_clr ? '0 : nxt_base;
    seq_len   = full_clr ? LEN_W'(TOTAL) : LEN_W'(P_COLS);
  end

  vram_clr_seq #(
    .P_ADR_BIT (P_ADR_BIT),
    .P_LEN_W   (LEN_W),
    .P_RST_LEN (TOTAL)
  ) u_clr_seq (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (seq_start),
    .base  (seq_base),
    .len   (seq_len),
    .adr   (seq_adr),
    .wr    (seq_wr),
    .done  (seq_done)
  );

  // Cursor and line base; a full clear only homes the cursor once its sweep completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cur_col <= '0;
      o_cur_row <= '0;
      line_base <= '0;
    end else if ((state == CLR_ALL) && seq_done && !i_clr) begin
      o_cur_col <= '0;
      o_cur_row <= '0;
      line_base <= '0;
    end else if (row_adv) begin
      o_cur_col <= '0;
      o_cur_row <= last_row ? 6'd0 : o_cur_row + 6'd1;
      line_base <= nxt_base;
    end else if (is_prt) begin
      o_cur_col <= o_cur_col + 7'd1;
    end else if (is_cr) begin
      o_cur_col <= '0;
    end else if (is_bs) begin
      o_cur_col <= o_cur_col - 7'd1;
    end
  end

  // Clear sweeps and byte writes never overlap: bytes are only accepted while the sequencer is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vram_wr_adr <= '0;
      o_vram_wr_en  <= 1'b0;
      o_vram_wr_chr <= '0;
      o_vram_wr_col <= '0;
      o_busy        <= 1'b1;
    end else begin
      o_vram_wr_en <= 1'b0;
      o_busy       <= (state != IDLE);
      if (seq_wr) begin
        o_vram_wr_en  <= 1'b1;
        o_vram_wr_adr <= seq_adr;
        o_vram_wr_chr <= P_CLR_CHR;
        o_vram_wr_col <= '0;
      end else if (is_prt) begin
        o_vram_wr_en  <= 1'b1;
        o_vram_wr_adr <= line_base + P_ADR_BIT'(o_cur_col);
        o_vram_wr_chr <= i_chr_dt;
        o_vram_wr_col <= i_col;
      end else if (is_bs) begin
        o_vram_wr_en  <= 1'b1;
        o_vram_wr_adr <= line_base + P_ADR_BIT'(o_cur_col - 7'd1);
        o_vram_wr_chr <= P_CLR_CHR;
        o_vram_wr_col <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_txt_wr.sv
// Scoreboard bench for vram_txt_wr: expected writes are queued by the stimulus, popped by a monitor.
module tb_vram_txt_wr;

  typedef struct packed {
    logic [12:0] adr;
    logic [7:0]  chr;
    logic [11:0] col;
    logic        busy;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chr_vld = 1'b0;
  logic [7:0]  chr_dt = 8'h00;
  logic [11:0] col_in = 12'h000;
  logic        clr = 1'b0;
  logic        chr_rdy;
  logic [12:0] wr_adr;
  logic        wr_en;
  logic [7:0]  wr_chr;
  logic [11:0] wr_col;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  vram_txt_wr dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_chr_vld     (chr_vld),
    .i_chr_dt      (chr_dt),
    .i_col         (col_in),
    .o_chr_rdy     (chr_rdy),
    .i_clr         (clr),
    .o_vram_wr_adr (wr_adr),
    .o_vram_wr_en  (wr_en),
    .o_vram_wr_chr (wr_chr),
    .o_vram_wr_col (wr_col),
    .o_cur_col     (cur_col),
    .o_cur_row     (cur_row),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got adr=%0d chr=%h col=%h busy=%0b, required no write",
                 wr_adr, wr_chr, wr_col, busy);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_adr !== e.adr || wr_chr !== e.chr || wr_col !== e.col || busy !== e.busy) begin
          errors++;
          $display("FAIL wr got adr=%0d chr=%h col=%h busy=%0b, required adr=%0d chr=%h col=%h busy=%0b",
                   wr_adr, wr_chr, wr_col, busy, e.adr, e.chr, e.col, e.busy);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic push(input int adr, input logic [7:0] c, input logic [11:0] co, input logic b);
    wr_t e;
    e.adr  = 13'(adr);
    e.chr  = c;
    e.col  = co;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic push_clr(input int base, input int len);
    for (int i = 0; i < len; i++) push(base + i, 8'h20, 12'h000, 1'b1);
  endtask

  // Always entered and left on a falling edge.
  task automatic send(input logic [7:0] d, input logic [11:0] c);
    int n = 0;
    while (!chr_rdy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got rdy=0 required rdy=1 for byte %h", d);
    end
    chr_vld = 1'b1;
    chr_dt  = d;
    col_in  = c;
    @(posedge clk);
    #1 chr_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && chr_rdy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d writes pending, required 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_cur(input string name, input int c, input int r);
    chk({name, "_col"}, int'(cur_col), c);
    chk({name, "_row"}, int'(cur_row), r);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_adr", int'(wr_adr), 0);
    chk("rst_wr_chr", int'(wr_chr), 0);
    chk("rst_busy", int'(busy), 1);
    chk_cur("rst_cur", 0, 0);
    push_clr(0, 4800);
    rst_n = 1'b1;
    wait_done("boot_clear");
    chk("boot_rdy", int'(chr_rdy), 1);
    chk_cur("boot_cur", 0, 0);

    // Single printable byte, strobe in the following cycle
    push(0, 8'h41, 12'hF00, 1'b0);
    send(8'h41, 12'hF00);
    chk("a_strobe_en", int'(wr_en), 1);
    chk("a_strobe_adr", int'(wr_adr), 0);
    wait_done("a");
    chk_cur("a_cur", 1, 0);

    // Full line of printables wraps into a line clear
    send(8'h0D, 12'h000);
    chk_cur("cr_cur", 0, 0);
    for (int i = 0; i < 80; i++) push(i, 8'h30 + 8'(i % 10), 12'h0F0, 1'b0);
    push_clr(80, 80);
    for (int i = 0; i < 80; i++) send(8'h30 + 8'(i % 10), 12'h0F0);
    n = 0;
    while (!chr_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wrap_rdy_low_cycles", n, 80);
    wait_done("wrap");
    chk_cur("wrap_cur", 0, 1);

    // Walk to the last row, then LF wraps to row 0
    for (int r = 2; r < 60; r++) begin
      push_clr(r * 80, 80);
      send(8'h0A, 12'h000);
    end
    wait_done("lf_walk");
    chk_cur("row59_cur", 0, 59);
    push_clr(0, 80);
    send(8'h0A, 12'h000);
    wait_done("lf_wrap");
    chk_cur("lf_wrap_cur", 0, 0);
    push(0, 8'h42, 12'h00F, 1'b0);
    send(8'h42, 12'h00F);
    wait_done("b");
    chk_cur("b_cur", 1, 0);

    // Backspace, CR, ignored control code
    push_clr(80, 80);
    send(8'h0A, 12'h000);
    push_clr(160, 80);
    send(8'h0A, 12'h000);
    for (int i = 0; i < 5; i++) begin
      push(160 + i, 8'h61 + 8'(i), 12'h123, 1'b0);
      send(8'h61 + 8'(i), 12'h123);
    end
    wait_done("row2");
    chk_cur("row2_cur", 5, 2);
    push(164, 8'h20, 12'h000, 1'b0);
    send(8'h08, 12'hABC);
    wait_done("bs");
    chk_cur("bs_cur", 4, 2);
    send(8'h0D, 12'h000);
    send(8'h08, 12'h000);
    send(8'h01, 12'h000);
    wait_done("bs0");
    chk_cur("bs0_cur", 0, 2);

    // Form feed acts as a full clear
    push_clr(0, 4800);
    send(8'h0C, 12'h000);
    wait_done("ff");
    chk_cur("ff_cur", 0, 0);

    // Clear request in the middle of a line clear, with a competing byte
    push_clr(80, 32);
    send(8'h0A, 12'h000);
    n = 0;
    while (!(wr_en && wr_adr == 13'd110) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL clr_mid_timeout got no write at adr 110, required one");
    end
    clr     = 1'b1;
    chr_vld = 1'b1;
    chr_dt  = 8'h5A;
    #1 chk("clr_blocks_rdy", int'(chr_rdy), 0);
    push_clr(0, 4800);
    @(posedge clk);
    #1 begin
      clr     = 1'b0;
      chr_vld = 1'b0;
    end
    @(negedge clk);
    wait_done("clr_mid");
    chk_cur("clr_mid_cur", 0, 0);
    push(0, 8'h43, 12'hF0F, 1'b0);
    send(8'h43, 12'hF0F);
    wait_done("c");
    chk_cur("c_cur", 1, 0);

    // Asynchronous reset in the middle of a full clear
    push_clr(0, 4800);
    send(8'h0C, 12'h000);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 begin
      rst_n = 1'b0;
      exp_q.delete();
    end
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_adr", int'(wr_adr), 0);
    chk("midrst_busy", int'(busy), 1);
    chk_cur("midrst_cur", 0, 0);
    push_clr(0, 4800);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("midrst_clear");
    chk("midrst_rdy", int'(chr_rdy), 1);
    push(0, 8'h45, 12'hFFF, 1'b0);
    send(8'h45, 12'hFFF);
    wait_done("e");
    chk_cur("e_cur", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_txt_wr.md
Name: vram_txt_wr

Overview:
- Text-console writer: the producer side of the VRAM that the VGA display path reads.
- Accepts a valid/ready byte stream of character codes and maintains a text cursor.
- Writes character code plus colour attribute into VRAM at row*P_COLS+col, one write per cycle.
- Handles control codes, line wrap, row wrap with line clear, and full-screen clear. Sits between the system/debug master and the VRAM write port.

Parameters:
- P_COLS, 80, characters per row.
- P_ROWS, 60, rows per screen.
- P_ADR_BIT, 13, VRAM address width; P_COLS*P_ROWS must be <= 2**P_ADR_BIT.
- P_CLR_CHR, 8'h20, character code written by clears.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_chr_vld  in  1  input byte valid.
- i_chr_dt  in  8  input byte (ASCII or control code).
- i_col  in  12  RGB444 attribute for the accepted byte.
- o_chr_rdy  out  1  byte accepted when i_chr_vld & o_chr_rdy.
- i_clr  in  1  full-screen clear request (single-cycle pulse).
- o_vram_wr_adr  out  P_ADR_BIT  VRAM write address.
- o_vram_wr_en  out  1  VRAM write strobe.
- o_vram_wr_chr  out  8  character code written.
- o_vram_wr_col  out  12  colour written.
- o_cur_col  out  7  cursor column.
- o_cur_row  out  6  cursor row.
- o_busy  out  1  high in any clear state.

Behaviour:
- One clock domain. Every output is registered except o_chr_rdy.
- Reset values: wr_adr 0, wr_en 0, wr_chr 0, wr_col 0, cursor (0,0), line_base 0, busy 1. State after reset is CLR_ALL, so the screen is blanked automatically.
- States:
  - IDLE: o_chr_rdy = ~i_clr.
  - CLR_ALL: writes P_CLR_CHR with colour 0 to addresses 0..P_COLS*P_ROWS-1, one per cycle. Then cursor=(0,0), line_base=0, go to IDLE.
  - CLR_LINE: writes P_CLR_CHR with colour 0 to line_base..line_base+P_COLS-1. Then go to IDLE.
- Addressing: keep a line_base register, incremented by P_COLS per row. No multiplier. Address = line_base + col.
- Latency: a byte accepted in cycle N produces its write strobe in cycle N+1.
- Accepted byte handling:
  - 0x20..0x7E: write {chr, i_col} at the cursor, then col+1.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0, row advance.
  - 0x08 (BS): if col>0, col-1 and write P_CLR_CHR at the new col with colour 0. If col=0, no-op.
  - 0x0C (FF): same as i_clr.
  - Any other code: ignored. Accepted, no write.
- Column wrap: a printable byte at col=P_COLS-1 is written there, then a row advance follows.
- Row advance: row+1 and line_base+P_COLS. At row P_ROWS-1 it wraps to row 0 with line_base 0. Always enters CLR_LINE for the new row, so o_chr_rdy is low for P_COLS cycles.
- i_clr: sampled in any state, including mid-CLR_LINE or mid-CLR_ALL. It restarts CLR_ALL from address 0. It has priority over a same-cycle i_chr_vld, which is not accepted.
- Asynchronous reset mid-clear aborts the clear immediately, with outputs at reset values. The clear is then restarted by the reset CLR_ALL.
- o_vram_wr_en is high exactly one cycle per write. No writes occur in IDLE without an accepted byte.

Decomposition:
- Shared package vram_txt_pkg:
  - state enum (IDLE, CLR_ALL, CLR_LINE);
  - ASCII control-code constants (CR, LF, BS, FF);
  - colour attribute typedef (12-bit RGB444).
- One natural sub-module: vram_clr_seq. It is a start/base/length address sequencer that emits a write strobe per cycle and a done pulse. It is shared by CLR_ALL (base 0, length P_COLS*P_ROWS) and CLR_LINE (base line_base, length P_COLS).

Test Plan:
- Reset release: 4800 strobes to addresses 0..4799 with chr 0x20 and col 0, busy high throughout. Then rdy=1, cursor (0,0).
- Send 'A' (0x41) with col 12'hF00: at the next cycle, adr=0, chr=0x41, col=F00, one strobe. Cursor becomes (1,0).
- Send 80 printable bytes from (0,0): last write at adr 79. Then 80 clear writes at 80..159 with rdy low. Cursor becomes (0,1).
- With cursor at row 59, send LF: 80 clear writes at 0..79, cursor (0,0).
- BS at (5,2): write 0x20 at adr 164, cursor (4,2). BS at (0,2): no write, cursor unchanged.
- Pulse i_clr at clear-write index 30 of a CLR_LINE, with i_chr_vld=1 in the same cycle: byte not accepted. CLR_ALL restarts at adr 0 and runs 4800 writes, ending at cursor (0,0).
